// File: rtl/cla_seq_add_ctrl.sv
// cla_seq_add_ctrl: runs one 4-bit carry-lookahead slice over WIDTH-bit operands, one nibble per clock, LSB first.
// Ports: clk, rst_n (async active-low); in_valid/in_ready + a, b, cin accept an operand pair in IDLE;
// out_valid/out_ready present the registered sum, cout (and ovf) in DONE; busy is high in RUN or DONE.
// Optional: define CLA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module cla_seq_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0][3:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] sl_a, sl_b, sl_s, g, p;
  logic [4:0] c;
  logic last;
`ifdef CLA_SEQ_OVF_EN
  logic ovf_q, ovf_d;
`endif
  // 4-bit carry-lookahead slice: all nibble carries from generate/propagate in one level
  always_comb begin
    sl_a = a_q[cnt_q];
    sl_b = b_q[cnt_q];
    g    = sl_a & sl_b;
    p    = sl_a ^ sl_b;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sl_s = p ^ c[3:0];
  end
  assign last = cnt_q == CW'(N - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        cnt_d   = '0;
        sum_d   = '0;
      end
      RUN: begin
        sum_d[cnt_q] = sl_s;
        carry_d      = c[4];
        // counter holds on the final nibble so it never wraps
        cnt_d        = last ? cnt_q : cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          cout_d  = c[4];
`ifdef CLA_SEQ_OVF_EN
          // carry into MSB xor carry out of MSB
          ovf_d   = a_q[N-1][3] ^ b_q[N-1][3] ^ sl_s[3] ^ c[4];
`endif
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// tb_cla_seq_add_ctrl: randomized and directed self-checking bench for cla_seq_add_ctrl against an arithmetic model.
module tb_cla_seq_add_ctrl;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;
  int checks = 0, errors = 0, cyc = 0;
`ifdef CLA_SEQ_OVF_EN
  logic ovf;
`endif
  cla_seq_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef CLA_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > 32767) || (s < -32768);
  endfunction
  task automatic chk_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] e;
    e = ref_add(x, y, c);
    chk({tag, "_sum"}, sum, e[W-1:0]);
    chk({tag, "_cout"}, cout, e[W]);
`ifdef CLA_SEQ_OVF_EN
    chk({tag, "_ovf"}, ovf, ref_ovf(x, y, c));
`endif
  endtask
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int stall);
    int n, lat;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_pre", in_ready, 1);
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 4);
    chk("busy_done", busy, 1);
    chk("in_ready_done", in_ready, 0);
    chk_result("res", x, y, c);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_ready", in_ready, 0);
      chk_result("stall", x, y, c);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_valid", out_valid, 0);
    chk("rel_ready", in_ready, 1);
    chk("rel_busy", busy, 0);
    chk_result("hold", x, y, c);
  endtask
  initial begin
    logic [W-1:0] ba [3];
    logic [W-1:0] bb [3];
    logic bc [3];
    logic [W-1:0] qa[$], qb[$];
    logic qc[$];
    int acc[$];
    int idx, got;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef CLA_SEQ_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h00FF, 16'h0001, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'h7FFF, 16'h0000, 1'b1, 0);
    do_op(16'h1234, 16'h4321, 1'b0, 5);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 2);
    // reset in the middle of a run
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
`ifdef CLA_SEQ_OVF_EN
    chk("mid_rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h0005, 16'h0003, 1'b1, 0);
    for (int i = 0; i < 20; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    // back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 3; i++) begin
      ba[i] = W'($urandom); bb[i] = W'($urandom); bc[i] = 1'($urandom);
    end
    idx = 0; got = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int t = 0; t < 40 && got < 3; t++) begin
      if (out_valid) begin
        if (qa.size() > 0) chk_result("b2b", qa.pop_front(), qb.pop_front(), qc.pop_front());
        got++;
      end
      if (in_ready && idx < 3) begin
        a = ba[idx]; b = bb[idx]; cin = bc[idx];
        qa.push_back(ba[idx]); qb.push_back(bb[idx]); qc.push_back(bc[idx]);
        acc.push_back(cyc);
        idx++;
      end else if (idx == 3) in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_results", got, 3);
    chk("b2b_accepts", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("b2b_gap0", acc[1] - acc[0], 6);
      chk("b2b_gap1", acc[2] - acc[1], 6);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
